// File: rtl/multdiv_sequencer.sv
// rtl/multdiv_sequencer.sv - iterative 32-step multiply/divide controller with pipeline stall
module multdiv_sequencer #(
    parameter int WIDTH = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic             is_div,
    input  logic             flush,
    input  logic [WIDTH-1:0] operand_a,
    input  logic [WIDTH-1:0] operand_b,
    input  logic [4:0]       rd_in,
    output logic             stall,
    output logic             result_valid,
    output logic [WIDTH-1:0] result,
    output logic [4:0]       rd_out,
    output logic             exception,
    output logic             busy
);

    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    count_q, count_d;
    logic             is_div_q, is_div_d;
    logic             neg_q, neg_d;
    logic             div_ovf_q, div_ovf_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic [WIDTH-1:0] b_mag_q, b_mag_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic [4:0]       rd_q, rd_d;
    logic             exc_q, exc_d;

    logic [WIDTH-1:0]   a_mag, b_mag;
    logic [WIDTH:0]     mul_sum, div_shift, div_diff;
    logic [WIDTH-1:0]   step_hi, step_lo;
    logic [2*WIDTH-1:0] prod, prod_s;
    logic [WIDTH-1:0]   quot_s;
    logic               mul_ovf;

    // Next-state logic: operand capture, one shift-add / subtract-shift step per RUN cycle, sign fix-up on the last step
    always_comb begin
        state_d   = state_q;
        count_d   = count_q;
        is_div_d  = is_div_q;
        neg_d     = neg_q;
        div_ovf_d = div_ovf_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        b_mag_d   = b_mag_q;
        result_d  = result_q;
        rd_d      = rd_q;
        exc_d     = exc_q;

        a_mag = operand_a[WIDTH-1] ? -operand_a : operand_a;
        b_mag = operand_b[WIDTH-1] ? -operand_b : operand_b;

        // Multiply keeps {hi,lo} as the partial product with the multiplier shifting out of lo;
        // divide keeps hi as the partial remainder and lo as dividend bits turning into quotient bits.
        mul_sum   = {1'b0, hi_q} + (lo_q[0] ? {1'b0, b_mag_q} : '0);
        div_shift = {hi_q, lo_q[WIDTH-1]};
        div_diff  = div_shift - {1'b0, b_mag_q};
        if (is_div_q) begin
            if (!div_diff[WIDTH]) begin
                step_hi = div_diff[WIDTH-1:0];
                step_lo = {lo_q[WIDTH-2:0], 1'b1};
            end else begin
                step_hi = div_shift[WIDTH-1:0];
                step_lo = {lo_q[WIDTH-2:0], 1'b0};
            end
        end else begin
            step_hi = mul_sum[WIDTH:1];
            step_lo = {mul_sum[0], lo_q[WIDTH-1:1]};
        end

        prod    = {step_hi, step_lo};
        prod_s  = neg_q ? -prod : prod;
        quot_s  = neg_q ? -step_lo : step_lo;
        mul_ovf = (prod_s[2*WIDTH-1:WIDTH] != {WIDTH{prod_s[WIDTH-1]}});

        case (state_q)
            S_IDLE: begin
                if (start && !flush) begin
                    is_div_d  = is_div;
                    neg_d     = operand_a[WIDTH-1] ^ operand_b[WIDTH-1];
                    div_ovf_d = is_div && (operand_a == {1'b1, {(WIDTH-1){1'b0}}}) && (operand_b == '1);
                    rd_d      = rd_in;
                    count_d   = '0;
                    b_mag_d   = b_mag;
                    hi_d      = '0;
                    lo_d      = a_mag;
                    if (is_div && (operand_b == '0)) begin
                        state_d  = S_DONE;
                        result_d = '0;
                        exc_d    = 1'b1;
                    end else begin
                        state_d = S_RUN;
                    end
                end
            end
            S_RUN: begin
                hi_d    = step_hi;
                lo_d    = step_lo;
                count_d = count_q + CW'(1);
                if (count_q == CW'(WIDTH-1)) begin
                    state_d  = S_DONE;
                    result_d = is_div_q ? quot_s : prod_s[WIDTH-1:0];
                    exc_d    = is_div_q ? div_ovf_q : mul_ovf;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        if (flush) state_d = S_IDLE;
    end

    // State and datapath registers with synchronous reset
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= S_IDLE;
            count_q   <= '0;
            is_div_q  <= 1'b0;
            neg_q     <= 1'b0;
            div_ovf_q <= 1'b0;
            hi_q      <= '0;
            lo_q      <= '0;
            b_mag_q   <= '0;
            result_q  <= '0;
            rd_q      <= '0;
            exc_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            is_div_q  <= is_div_d;
            neg_q     <= neg_d;
            div_ovf_q <= div_ovf_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            b_mag_q   <= b_mag_d;
            result_q  <= result_d;
            rd_q      <= rd_d;
            exc_q     <= exc_d;
        end
    end

    // Stall rises combinationally in the accepting cycle and drops in DONE so the pipeline advances
    always_comb begin
        stall        = ((state_q == S_IDLE) && start && !flush) || (state_q == S_RUN);
        result_valid = (state_q == S_DONE) && !flush;
        busy         = (state_q != S_IDLE);
        result       = result_q;
        rd_out       = rd_q;
        exception    = exc_q;
    end

endmodule

// File: doc/multdiv_sequencer.md
# multdiv_sequencer

Multi-cycle controller for the processor's shared iterative multiply/divide unit. Sits beside the execute stage: when decode flags a `mul` or `div` ALU op, it captures the operands and runs a 32-step shift-add multiply or restoring divide. While running it holds the pipeline stalled, then presents a 32-bit result plus exception flag for one cycle. The writeback path uses that flag to redirect to r30, the same way `setx`/`bex` use rstatus.

## Interface
- `WIDTH`, 32: operand/result width; the step count equals `WIDTH`.
- `clock`  in  1: single clock, rising-edge.
- `reset`  in  1: synchronous, active-high.
- `start`  in  1: execute-stage instruction is mul/div; level, sampled only in IDLE.
- `is_div`  in  1: 1 = divide, 0 = multiply; sampled with `start`.
- `flush`  in  1: cancel any in-flight operation (branch/jump redirect).
- `operand_a`  in  WIDTH: multiplicand / dividend, two's complement.
- `operand_b`  in  WIDTH: multiplier / divisor, two's complement.
- `rd_in`  in  5: destination register of the op.
- `stall`  out  1: freeze PC and pipeline registers ahead of execute.
- `result_valid`  out  1: one-cycle pulse; `result`, `rd_out` and `exception` are valid.
- `result`  out  WIDTH: low WIDTH bits of product, or quotient.
- `rd_out`  out  5: captured `rd_in`.
- `exception`  out  1: overflow or divide-by-zero; writeback writes r30 with 1 (mul) or 2 (div).
- `busy`  out  1: state != IDLE.

## Operation
- States: IDLE, RUN, DONE.
- IDLE, `start`=1, `flush`=0: capture operands, `is_div` and `rd_in`. Clear the step counter.
  - Divide with `operand_b`==0: go to DONE with exception pending and result 0.
  - Otherwise go to RUN.
- RUN, multiply: 64-bit product on the magnitudes. One add/shift step per cycle.
- RUN, divide: restoring algorithm on the magnitudes. One subtract/shift step per cycle.
- RUN: the counter increments 0..WIDTH-1. On the step with counter==WIDTH-1, go to DONE.
- DONE: apply the sign, drive `result_valid`=1, then return to IDLE unconditionally. `start` is ignored in DONE because the same instruction is still in execute.
- Sign rules:
  - Product sign is a[31]^b[31].
  - Quotient truncates toward zero; the remainder is discarded.
- Multiply overflow: the signed 64-bit product's upper 32 bits differ from 32 copies of `result[31]`. Sets `exception`; `result` still carries the low 32 bits.
- Divide overflow: `0x80000000 / -1` returns `0x80000000` with `exception`=1.
- `exception` is 0 in all other cases.
- `flush`, any state: go to IDLE next cycle and suppress `result_valid`. In DONE, `flush` also suppresses the output that same cycle. In IDLE, `flush` beats `start`.
- `stall` = (IDLE & `start` & ~`flush`) | RUN. It is combinational from `start`, so it is raised in the accepting cycle. It is 0 in DONE, so the pipeline advances at the end of DONE.
- Only `result_valid` gates use of `result`, `rd_out` and `exception`. They hold their last values otherwise.

## Timing
- Reset: state IDLE, counter 0. `stall`, `busy`, `result_valid` and `exception` are 0. `result` and `rd_out` are 0.
- Normal op accepted at edge k (IDLE, `start`=1):
  - RUN during cycles k+1..k+WIDTH.
  - DONE at cycle k+WIDTH+1 (k+33 for WIDTH=32), with `result_valid` high that cycle only.
- Divide-by-zero accepted at edge k: DONE at cycle k+1.
- Back-to-back ops: the earliest next accept is the IDLE cycle after DONE, i.e. a 1-cycle bubble.
- Reset mid-operation: IDLE next cycle with no `result_valid`, same as `flush`.

## Test plan
- mul 7 × -6, `rd_in`=5: `stall` high 33 cycles, then exactly one `result_valid` with `result`=0xFFFFFFD6, `rd_out`=5, `exception`=0.
- mul 0x00010000 × 0x00010000: `result`=0x00000000, `exception`=1. mul 0x7FFFFFFF × 1: `exception`=0.
- div -7 / 2: `result`=0xFFFFFFFD (-3). div 100 / 7: `result`=14. div 0x80000000 / -1: `result`=0x80000000, `exception`=1.
- div 5 / 0: `result_valid` one cycle after accept, `result`=0, `exception`=1, `stall` high only in the accept cycle.
- `flush` at RUN step 10, with `start` still high that cycle: IDLE next cycle, no `result_valid`. A new `start` afterwards completes normally. Separately, `flush` during DONE: `result_valid` stays 0.
- Two consecutive muls with `start` held through DONE: two `result_valid` pulses 34 cycles apart. `start` in DONE does not retrigger; a synchronous `reset` pulse mid-RUN returns all outputs to reset values.
